// File: rtl/pipe_trace_buffer.sv
// Triggerable circular trace buffer for the MIPS32 pipeline probes.
// Captures NUM_CH words per sample, keeps POST_TRIG samples after the trigger, then drains oldest-first.
module pipe_trace_buffer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned TS_W      = 16,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CH*32-1:0]   probe_in,
    input  logic                   probe_valid,
    input  logic                   arm,
    input  logic                   trigger,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_data,
    output logic [CW-1:0]          rd_ch,
    output logic [TS_W-1:0]        rd_ts,
    output logic                   rd_trig,
    output logic                   rd_last,
    output logic                   capt_done,
    output logic [1:0]             state,
    output logic [AW:0]            fill
);

    localparam int unsigned DW = NUM_CH * 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_READ  = 2'd3
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   wp_q;
    logic [AW:0]     fill_q;
    logic [AW:0]     post_cnt_q;
    logic [TS_W-1:0] ts_q;
    logic [AW:0]     rd_pos_q;
    logic [CW-1:0]   rd_ch_q;
    logic            capt_done_q;

    logic [DW-1:0]   data_mem [DEPTH];
    logic [TS_W-1:0] ts_mem   [DEPTH];

    logic            wr_en;
    logic [AW:0]     fill_d;
    logic [AW:0]     post_cnt_d;
    logic            full;
    logic [AW-1:0]   rd_base;
    logic [AW-1:0]   rd_idx;
    logic [DW-1:0]   rd_entry;
    logic [31:0]     rd_word;
    logic [AW:0]     trig_pos;
    logic            ch_last;
    logic            pos_last;

    assign wr_en      = probe_valid && ((state_q == S_ARMED) || (state_q == S_POST));
    assign full       = (fill_q == (AW+1)'(DEPTH));
    assign fill_d     = full ? fill_q : fill_q + (AW+1)'(1);
    assign post_cnt_d = post_cnt_q + (AW+1)'(1);

    // Once the buffer has wrapped, the write pointer is also the oldest entry.
    assign rd_base  = full ? wp_q : '0;
    assign rd_idx   = rd_base + rd_pos_q[AW-1:0];
    assign rd_entry = data_mem[rd_idx];
    assign trig_pos = fill_q - (AW+1)'(POST_TRIG + 1);
    assign ch_last  = (rd_ch_q == CW'(NUM_CH - 1));
    assign pos_last = (rd_pos_q == fill_q - (AW+1)'(1));

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (rd_ch_q == CW'(c)) rd_word = rd_entry[c*32 +: 32];
        end
    end

    // Readout fields are forced to zero outside READ so they idle at their reset values.
    assign rd_valid  = (state_q == S_READ);
    assign rd_data   = rd_valid ? rd_word : '0;
    assign rd_ch     = rd_valid ? rd_ch_q : '0;
    assign rd_ts     = rd_valid ? ts_mem[rd_idx] : '0;
    assign rd_trig   = rd_valid && (rd_pos_q == trig_pos);
    assign rd_last   = rd_valid && pos_last && ch_last;
    assign capt_done = capt_done_q;
    assign state     = state_q;
    assign fill      = fill_q;

    // Sample storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wp_q] <= probe_in;
            ts_mem[wp_q]   <= ts_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wp_q        <= '0;
            fill_q      <= '0;
            post_cnt_q  <= '0;
            ts_q        <= '0;
            rd_pos_q    <= '0;
            rd_ch_q     <= '0;
            capt_done_q <= 1'b0;
        end else begin
            capt_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q    <= S_ARMED;
                        wp_q       <= '0;
                        fill_q     <= '0;
                        post_cnt_q <= '0;
                        ts_q       <= '0;
                        rd_pos_q   <= '0;
                        rd_ch_q    <= '0;
                    end
                end
                S_ARMED: begin
                    ts_q <= ts_q + TS_W'(1);
                    if (probe_valid) begin
                        wp_q   <= wp_q + AW'(1);
                        fill_q <= fill_d;
                        if (trigger) begin
                            if (POST_TRIG == 0) begin
                                state_q     <= S_READ;
                                capt_done_q <= 1'b1;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    ts_q <= ts_q + TS_W'(1);
                    if (probe_valid) begin
                        wp_q       <= wp_q + AW'(1);
                        fill_q     <= fill_d;
                        post_cnt_q <= post_cnt_d;
                        if (post_cnt_d == (AW+1)'(POST_TRIG)) begin
                            state_q     <= S_READ;
                            capt_done_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        if (ch_last) begin
                            rd_ch_q  <= '0;
                            rd_pos_q <= rd_pos_q + (AW+1)'(1);
                            if (pos_last) state_q <= S_IDLE;
                        end else begin
                            rd_ch_q <= rd_ch_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer with NUM_CH=2, DEPTH=8, POST_TRIG=3.
module tb_pipe_trace_buffer;

    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 3;
    localparam int unsigned TS_W      = 16;
    localparam int unsigned AW        = 3;
    localparam int unsigned CW        = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_CH*32-1:0] probe_in;
    logic                 probe_valid;
    logic                 arm;
    logic                 trigger;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [31:0]          rd_data;
    logic [CW-1:0]        rd_ch;
    logic [TS_W-1:0]      rd_ts;
    logic                 rd_trig;
    logic                 rd_last;
    logic                 capt_done;
    logic [1:0]           state;
    logic [AW:0]          fill;

    int n_cmp = 0;
    int n_err = 0;

    pipe_trace_buffer #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .probe_in(probe_in), .probe_valid(probe_valid),
        .arm(arm), .trigger(trigger), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_ts(rd_ts), .rd_trig(rd_trig),
        .rd_last(rd_last), .capt_done(capt_done), .state(state), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic put(input int k, input bit trig);
        probe_in    = {32'(k + 100), 32'(k)};
        probe_valid = 1'b1;
        trigger     = trig;
        step();
        probe_valid = 1'b0;
        trigger     = 1'b0;
    endtask

    // Drains n entries starting at sample 'first'; samples after gap_s were taken one cycle late.
    task automatic drain(input int first, input int n, input int trig_s, input int gap_s, input bit bp);
        int w = 0;
        int c = 0;
        int s;
        int ch;
        logic [63:0] exp_v;
        logic [63:0] obs_v;
        while (w < 2 * n && c < 400) begin
            rd_ready = bp ? (c % 3 == 0) : 1'b1;
            s  = first + w / 2;
            ch = w % 2;
            exp_v = {12'd0, 1'b1, (ch == 1) ? 32'(s + 100) : 32'(s), 1'(ch),
                     16'(s - 1 + ((s > gap_s) ? 1 : 0)), 1'(s == trig_s), 1'(w == 2 * n - 1)};
            obs_v = {12'd0, rd_valid, rd_data, rd_ch, rd_ts, rd_trig, rd_last};
            check("rd_word", obs_v, exp_v);
            if (rd_ready) w++;
            c++;
            step();
        end
        rd_ready = 1'b0;
        if (w < 2 * n) check("drain_timeout", 64'(w), 64'(2 * n));
        check("idle_after_drain", {62'd0, state}, 64'd0);
        check("valid_after_drain", {63'd0, rd_valid}, 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        probe_in    = '0;
        probe_valid = 1'b0;
        arm         = 1'b0;
        trigger     = 1'b0;
        rd_ready    = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset and idle
        check("rst_state", {62'd0, state}, 64'd0);
        check("rst_fill", {60'd0, fill}, 64'd0);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_capt_done", {63'd0, capt_done}, 64'd0);
        check("rst_rd_fields", {13'd0, rd_data, rd_ch, rd_ts, rd_trig, rd_last}, 64'd0);
        put(7, 1'b1);
        put(8, 1'b0);
        check("idle_no_arm_state", {62'd0, state}, 64'd0);
        check("idle_no_arm_fill", {60'd0, fill}, 64'd0);

        // Short capture
        do_arm();
        check("armed_state", {62'd0, state}, 64'd1);
        put(1, 1'b0);
        put(2, 1'b1);
        check("post_state", {62'd0, state}, 64'd2);
        put(3, 1'b0);
        put(4, 1'b0);
        check("post_no_done", {63'd0, capt_done}, 64'd0);
        put(5, 1'b0);
        check("short_read_state", {62'd0, state}, 64'd3);
        check("short_fill", {60'd0, fill}, 64'd5);
        check("short_capt_done", {63'd0, capt_done}, 64'd1);
        step();
        check("short_capt_done_pulse", {63'd0, capt_done}, 64'd0);
        drain(1, 5, 2, 1000, 1'b0);

        // Wrap-around
        do_arm();
        for (int k = 1; k <= 24; k++) put(k, k == 21);
        check("wrap_state", {62'd0, state}, 64'd3);
        check("wrap_fill", {60'd0, fill}, 64'd8);
        drain(17, 8, 21, 1000, 1'b0);

        // Backpressure on the short capture
        do_arm();
        put(1, 1'b0);
        put(2, 1'b1);
        put(3, 1'b0);
        put(4, 1'b0);
        put(5, 1'b0);
        check("bp_state", {62'd0, state}, 64'd3);
        drain(1, 5, 2, 1000, 1'b1);

        // Gaps and ignored inputs
        do_arm();
        put(1, 1'b0);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("trig_no_valid_state", {62'd0, state}, 64'd1);
        check("trig_no_valid_fill", {60'd0, fill}, 64'd1);
        put(2, 1'b1);
        put(3, 1'b0);
        put(4, 1'b0);
        put(5, 1'b0);
        check("gap_state", {62'd0, state}, 64'd3);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_in_read_state", {62'd0, state}, 64'd3);
        put(9, 1'b1);
        check("write_in_read_fill", {60'd0, fill}, 64'd5);
        drain(1, 5, 2, 1, 1'b0);

        // Reset mid-POST
        do_arm();
        put(1, 1'b1);
        put(2, 1'b0);
        check("pre_abort_state", {62'd0, state}, 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("abort_state", {62'd0, state}, 64'd0);
        check("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("abort_fill", {60'd0, fill}, 64'd0);
        step();
        reset = 1'b0;
        step();
        do_arm();
        put(1, 1'b1);
        put(2, 1'b0);
        put(3, 1'b0);
        put(4, 1'b0);
        check("fresh_state", {62'd0, state}, 64'd3);
        check("fresh_fill", {60'd0, fill}, 64'd4);
        drain(1, 4, 1, 1000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

On-chip trace capture for the pipelined MIPS32 core. It continuously records NUM_CH 32-bit probe words per sample, for example PC, IF/ID instruction, ALU result and MEM/WB result, into a circular buffer once armed. It keeps POST_TRIG samples after a trigger, then drains the captured window oldest-first over a valid/ready stream. It sits beside the `mips_32` core and replaces per-cycle console dumps with a bounded, triggerable trace that hardware can read back.

## Interface
Parameters:
- NUM_CH, 4: 32-bit probe channels per sample; ≥1.
- DEPTH, 16: samples stored; power of 2, ≥2.
- POST_TRIG, 8: samples kept after the trigger sample; 0 ≤ POST_TRIG ≤ DEPTH-1.
- TS_W, 16: timestamp width.

Ports (derived widths: AW = $clog2(DEPTH), CW = max(1, $clog2(NUM_CH))):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- probe_in  in  NUM_CH*32  channel c occupies bits [32c+31:32c].
- probe_valid  in  1  sample this cycle.
- arm  in  1  start a capture; honoured only in IDLE.
- trigger  in  1  trigger; honoured only in ARMED and only together with probe_valid.
- rd_valid  out  1  readout word available.
- rd_ready  in  1  consumer accepts word.
- rd_data  out  32  readout word.
- rd_ch  out  CW  channel of rd_data.
- rd_ts  out  TS_W  timestamp of the sample rd_data belongs to.
- rd_trig  out  1  rd_data belongs to the trigger sample.
- rd_last  out  1  final word of the readout.
- capt_done  out  1  one-cycle pulse on entry to READ.
- state  out  2  IDLE=0, ARMED=1, POST=2, READ=3.
- fill  out  AW+1  valid samples in the buffer.

## Operation
- Storage is DEPTH entries, each holding NUM_CH×32 data bits plus TS_W timestamp bits. Contents are not cleared by reset.
- Write pointer wp is AW bits and wraps at DEPTH. fill saturates at DEPTH. post_cnt counts samples taken in POST.
- Timestamp counter ts is TS_W bits. It clears to 0 on arm and increments by 1 every cycle in ARMED or POST, wrapping modulo 2^TS_W. A stored sample carries the ts value of its write cycle.
- IDLE: arm=1 → ARMED, with wp=0, fill=0, ts=0, post_cnt=0.
- ARMED, probe_valid=1: write probe_in to entry wp, wp+1, fill+1 (saturating).
  - If trigger=1 in the same cycle, that sample is the trigger sample. Go to POST, or to READ if POST_TRIG=0.
  - trigger with probe_valid=0 is ignored.
- POST, probe_valid=1: write as in ARMED and increment post_cnt. The write that brings post_cnt to POST_TRIG moves the FSM to READ. When fill is already DEPTH, post-trigger writes overwrite the oldest entries.
- READ:
  - Oldest entry index is wp if fill=DEPTH, else 0.
  - Words are emitted entry-by-entry, oldest first, channel 0..NUM_CH-1 within each entry, fill×NUM_CH words in total.
  - The trigger entry sits at readout position fill-1-POST_TRIG. rd_trig is high for all NUM_CH words of that entry.
  - rd_last is high on the final word. Acceptance of that word (rd_valid&rd_ready) → IDLE.
- arm outside IDLE is ignored. probe_valid and trigger in READ are ignored, and no writes occur.
- rd_ch, rd_ts, rd_trig and rd_last are meaningful only while rd_valid=1.

## Timing
- Reset (async assert): state=IDLE, rd_valid=0, capt_done=0, fill=0, wp=0, post_cnt=0, ts=0, rd_data/rd_ch/rd_ts/rd_trig/rd_last=0.
- Reset mid-capture or mid-readout aborts to IDLE immediately. Nothing is drained.
- Writes take effect at the rising edge of the cycle in which probe_valid=1. fill and state reflect them one cycle later.
- capt_done=1 and rd_valid=1 in the first READ cycle, i.e. the cycle after the final post-trigger write.
- Readout throughput is one word per cycle with rd_ready held high. rd_valid stays high until the last word is accepted.
- While rd_valid=1 and rd_ready=0, rd_data, rd_ch, rd_ts, rd_trig and rd_last hold stable.
- The buffer read may be combinational from the register array. Outputs must settle within the cycle, with no extra latency.
- With fill=DEPTH, wp=oldest. Readout order wraps from entry DEPTH-1 to entry 0.

## Test plan
Parameters for all scenarios: NUM_CH=2, DEPTH=8, POST_TRIG=3. Sample k drives ch0=k, ch1=k+100.

1. Reset and idle: after reset, state=0, fill=0, rd_valid=0. probe_valid and trigger pulses with no arm → no state change.
2. Short capture: arm; samples 1–5 on consecutive cycles, trigger with sample 2 → READ, fill=5, capt_done pulses once.
   - Readout is 1,101,2,102,…,5,105 (10 words), rd_trig on words 3–4, rd_last on word 10, rd_ts 0,0,1,1,…,4,4.
3. Wrap-around: arm; samples 1–20, trigger with sample 21, then samples 22–24 → fill=8. Readout is samples 17..24 (16 words), rd_trig on sample 21 (words 9–10).
4. Backpressure: during readout in scenario 2, rd_ready toggles 1,0,0,1,… → every word is delivered once, in order. Output fields are unchanged across stall cycles.
5. Gaps and ignored inputs:
   - arm; trigger with probe_valid=0 → stays ARMED.
   - probe_valid pattern 1,0,1 → stored timestamps 0,2.
   - arm during READ → ignored.
6. Reset mid-POST: arm, trigger, one post sample, assert reset → state=0, rd_valid=0, fill=0. A fresh arm starts a clean capture with ts from 0.
